// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM encoding,
// default mult/div latency and the front-end strobe bundle.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int MD_LATENCY_DEF = 32;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_flush;
    } strobe_t;

    localparam strobe_t STB_HOLD     = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam strobe_t STB_STALL    = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
    localparam strobe_t STB_REDIRECT = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
    localparam strobe_t STB_ADVANCE  = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};

endpackage

// File: rtl/md_countdown.sv
// Mult/div occupancy counter: load restarts the count, otherwise it runs
// down to zero and emits a one-cycle registered done pulse on arrival.
module md_countdown #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_busy,
    output logic o_done
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_LATENCY - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load) begin
                r_cnt <= LOAD_VAL;
            end else if (r_cnt != '0) begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_done <= (r_cnt == CNT_W'(1));
            end
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_done = r_done;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory wait,
// hazard stalls, mult/div occupancy and ID redirects into register strobes.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY  = MD_LATENCY_DEF,
    parameter int CNT_W       = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hazard_stall,
    input  logic                   branch_taken_id,
    input  logic                   jump_id,
    input  logic                   md_start_ex,
    input  logic                   md_use_id,
    input  logic                   dmem_req_mem,
    input  logic                   dmem_ready,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_we,
    output logic                   md_busy,
    output logic                   md_done,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   w_freeze;
    logic                   w_front_stall;
    logic                   w_redirect;
    strobe_t                w_stb;
    logic                   w_exmem_we;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:      if (dmem_req_mem && !dmem_ready) w_state_nxt = MEM_WAIT;
            MEM_WAIT: if (dmem_ready)                  w_state_nxt = RUN;
            default:                                   w_state_nxt = RUN;
        endcase
    end

    // The ready cycle of a memory wait is already an advancing cycle.
    assign w_freeze      = ((r_state == RUN) && dmem_req_mem && !dmem_ready) ||
                           ((r_state == MEM_WAIT) && !dmem_ready);
    assign w_front_stall = hazard_stall || (md_use_id && md_busy);
    assign w_redirect    = branch_taken_id || jump_id;

    // A redirect under a front stall is dropped; the branch re-resolves later.
    always_comb begin
        w_stb      = STB_ADVANCE;
        w_exmem_we = 1'b1;
        if (rst || w_freeze) begin
            w_stb      = STB_HOLD;
            w_exmem_we = 1'b0;
        end else if (w_front_stall) begin
            w_stb = STB_STALL;
        end else if (w_redirect) begin
            w_stb = STB_REDIRECT;
        end
    end

    assign pc_we      = w_stb.pc_we;
    assign ifid_we    = w_stb.ifid_we;
    assign ifid_flush = w_stb.ifid_flush;
    assign idex_flush = w_stb.idex_flush;
    assign exmem_we   = w_exmem_we;

    // A frozen mult/div issue is ignored; the instruction stays in EX and reissues.
    md_countdown #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md (
        .clk    (clk),
        .rst    (rst),
        .i_load (md_start_ex && !w_freeze),
        .o_busy (md_busy),
        .o_done (md_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (!w_stb.pc_we && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a cycle-level behavioural model
// checked every negedge, plus hand-computed literal checks.
module tb_pipeline_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 3;
    localparam int SW  = 4;
    localparam int SAT = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hazard_stall = 1'b0, branch_taken_id = 1'b0, jump_id = 1'b0;
    logic          md_start_ex = 1'b0, md_use_id = 1'b0;
    logic          dmem_req_mem = 1'b0, dmem_ready = 1'b0;
    logic          pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, md_busy, md_done;
    logic [SW-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    pipeline_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .hazard_stall(hazard_stall), .branch_taken_id(branch_taken_id), .jump_id(jump_id),
        .md_start_ex(md_start_ex), .md_use_id(md_use_id),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_we(exmem_we), .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Model: is a memory access outstanding, mult/div cycles left, done flag, stall count.
    bit m_wait   = 1'b0;
    int m_left   = 0;
    bit m_done   = 1'b0;
    int m_stalls = 0;

    function automatic bit model_freeze();
        return !dmem_ready && (m_wait || dmem_req_mem);
    endfunction

    // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we}
    function automatic logic [4:0] model_strobes();
        if (model_freeze())                              return 5'b00000;
        if (hazard_stall || (md_use_id && m_left > 0))   return 5'b00011;
        if (branch_taken_id || jump_id)                  return 5'b11101;
        return 5'b11001;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait = 1'b0; m_left = 0; m_done = 1'b0; m_stalls = 0;
        end else begin
            logic [4:0] s;
            bit         frz;
            s   = model_strobes();
            frz = model_freeze();
            if (!s[4] && m_stalls < SAT) m_stalls = m_stalls + 1;
            m_wait = dmem_ready ? 1'b0 : (m_wait || dmem_req_mem);
            m_done = 1'b0;
            if (md_start_ex && !frz) m_left = LAT - 1;
            else if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0]     es;
        logic [SW+6:0]  exp_v, act_v;
        es    = rst ? 5'b00000 : model_strobes();
        exp_v = {es, (m_left > 0), m_done, SW'(m_stalls)};
        act_v = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, md_busy, md_done, stall_cycles};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_cycle t=%0t got=%b expected=%b", $time, act_v, exp_v);
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp_v);
        end
    endtask

    task automatic idle();
        hazard_stall = 0; branch_taken_id = 0; jump_id = 0;
        md_start_ex = 0; md_use_id = 0; dmem_req_mem = 0; dmem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        samp();
        chk("rst_pc_we", pc_we, 0);
        chk("rst_exmem_we", exmem_we, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        tick();
        rst = 1'b0;

        // Idle after reset: everything advances.
        samp();
        chk("idle_pc_we", pc_we, 1);
        chk("idle_ifid_we", ifid_we, 1);
        chk("idle_exmem_we", exmem_we, 1);
        chk("idle_flushes", {ifid_flush, idex_flush}, 0);
        chk("idle_stall_cycles", stall_cycles, 0);

        // Stall suppresses a coincident branch; it re-resolves next cycle.
        tick(); hazard_stall = 1; branch_taken_id = 1;
        samp();
        chk("stall_pc_we", pc_we, 0);
        chk("stall_idex_flush", idex_flush, 1);
        chk("stall_ifid_flush", ifid_flush, 0);
        tick(); hazard_stall = 0;
        samp();
        chk("redir_ifid_flush", ifid_flush, 1);
        chk("redir_pc_we", pc_we, 1);
        chk("redir_stall_cycles", stall_cycles, 1);
        tick(); branch_taken_id = 0;

        // Mult/div occupancy with a dependent instruction waiting in ID.
        md_start_ex = 1;
        samp();
        chk("md_t0_busy", md_busy, 0);
        tick(); md_start_ex = 0; md_use_id = 1;
        for (int t = 1; t <= 3; t++) begin
            samp();
            chk("md_busy_t", md_busy, 1);
            chk("md_pc_we_t", pc_we, 0);
            tick();
        end
        samp();
        chk("md_t4_busy", md_busy, 0);
        chk("md_t4_done", md_done, 1);
        chk("md_t4_pc_we", pc_we, 1);
        tick(); md_use_id = 0;
        samp();
        chk("md_t5_done", md_done, 0);

        // Memory wait: 3 frozen cycles, third with request dropped to probe MEM_WAIT.
        do_reset();
        dmem_req_mem = 1; dmem_ready = 0;
        for (int t = 0; t < 3; t++) begin
            if (t == 2) dmem_req_mem = 0;
            samp();
            chk("mem_pc_we", pc_we, 0);
            chk("mem_ifid_we", ifid_we, 0);
            chk("mem_exmem_we", exmem_we, 0);
            tick();
        end
        dmem_req_mem = 1; dmem_ready = 1;
        samp();
        chk("mem_ready_pc_we", pc_we, 1);
        chk("mem_ready_exmem_we", exmem_we, 1);
        chk("mem_stall_cycles", stall_cycles, 3);
        tick(); idle();
        samp();
        chk("mem_after_pc_we", pc_we, 1);

        // Mult/div issue during freeze is ignored; reissue on the ready cycle loads.
        tick(); dmem_req_mem = 1; dmem_ready = 0; md_start_ex = 1;
        samp();
        chk("frz_md_busy0", md_busy, 0);
        tick(); dmem_ready = 1;
        samp();
        chk("frz_md_busy1", md_busy, 0);
        tick(); idle();
        samp();
        chk("reissue_md_busy", md_busy, 1);

        // Freeze outranks a stall; a lone jump redirects.
        tick(); hazard_stall = 1; jump_id = 1; dmem_req_mem = 1;
        samp();
        chk("frz_over_stall_idex", idex_flush, 0);
        tick(); hazard_stall = 0; dmem_req_mem = 0; dmem_ready = 1;
        samp();
        chk("jump_ifid_flush", ifid_flush, 1);
        tick(); idle();

        // Mixed traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 200; i++) begin
            hazard_stall    = ($urandom_range(0, 5) == 0);
            branch_taken_id = ($urandom_range(0, 4) == 0);
            jump_id         = ($urandom_range(0, 7) == 0);
            md_start_ex     = ($urandom_range(0, 6) == 0);
            md_use_id       = ($urandom_range(0, 2) == 0);
            dmem_req_mem    = ($urandom_range(0, 3) == 0);
            dmem_ready      = ($urandom_range(0, 2) != 0);
            tick();
        end

        // Stall counter saturation, then asynchronous reset mid-stall.
        do_reset();
        hazard_stall = 1;
        md_start_ex  = 1;
        tick(); md_start_ex = 0;
        repeat (19) tick();
        samp();
        chk("sat_stall_cycles", stall_cycles, SAT);
        chk("sat_pc_we", pc_we, 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_pc_we", pc_we, 0);
        chk("arst_ifid_we", ifid_we, 0);
        chk("arst_exmem_we", exmem_we, 0);
        chk("arst_idex_flush", idex_flush, 0);
        chk("arst_stall_cycles", stall_cycles, 0);
        chk("arst_md_busy", md_busy, 0);
        tick(); rst = 1'b0; idle();
        samp();
        chk("post_rst_pc_we", pc_we, 1);
        chk("post_rst_stall_cycles", stall_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
